emitter_uart_fifo: RTL and testbench

Parametrised successor to the single-byte UART emitter that turns the corescore byte stream into serial output.
- Accepts bytes over an AXI-stream-style handshake (tdata/tlast/tvalid/tready) into a power-of-two FIFO.
- Serialises them as 8-bit UART frames with configurable baud divisor, stop-bit count and parity mode.
- Reports FIFO fill level and pulses a done flag when a byte tagged tlast finishes transmission.
- Sits between corescorecore and the board pin in every top-level.

---
 rtl/emitter_uart_fifo.sv | 154 +++++++++++++++
 tb/tb_emitter_uart_fifo.sv | 355 +++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/emitter_uart_fifo.sv
// Byte-stream UART transmitter: AXI-stream style input into a power-of-two FIFO,
// serialised as 8-bit frames with configurable divisor, parity and stop bits.
module emitter_uart_fifo #(
  parameter int CLK_FREQ  = 16000000,
  parameter int BAUD      = 57600,
  parameter int DEPTH     = 16,
  parameter int STOP_BITS = 1,
  parameter int PARITY    = 0,
  localparam int AW       = $clog2(DEPTH)
) (
  input  logic          i_clk,
  input  logic          i_rst,
  input  logic [7:0]    i_tdata,
  input  logic          i_tlast,
  input  logic          i_tvalid,
  output logic          o_tready,
  output logic          o_uart_tx,
  output logic [AW:0]   o_level,
  output logic          o_busy,
  output logic          o_frame_done
);

  localparam int              DIV       = CLK_FREQ / BAUD;
  localparam int              CW        = $clog2(DIV);
  localparam int              LW        = AW + 1;
  localparam logic [CW-1:0]   DIV_M1    = CW'(DIV - 1);
  localparam logic [CW-1:0]   BAUD_ONE  = CW'(1);
  localparam logic [AW-1:0]   PTR_ONE   = AW'(1);
  localparam logic [LW-1:0]   FULL_CNT  = LW'(DEPTH);
  localparam logic [2:0]      LAST_STOP = 3'(STOP_BITS - 1);

  typedef enum logic [2:0] {S_IDLE, S_START, S_DATA, S_PAR, S_STOP} state_t;

  logic [8:0]    r_mem [DEPTH];
  logic [AW-1:0] r_wr_ptr, r_rd_ptr;
  logic [LW-1:0] r_count;

  state_t        r_state;
  logic [CW-1:0] r_baud;
  logic [2:0]    r_bit;
  logic [7:0]    r_shift;
  logic          r_last;
  logic          r_par;

  logic          w_full, w_empty, w_push, w_pop, w_frame_end;
  logic [8:0]    w_head;

  assign w_full      = (r_count == FULL_CNT);
  assign w_empty     = (r_count == '0);
  assign o_tready    = !w_full && !i_rst;
  assign w_push      = i_tvalid && o_tready;
  assign w_frame_end = (r_state == S_STOP) && (r_baud == '0) && (r_bit == LAST_STOP);
  // A new frame starts from IDLE or straight out of the final stop-bit cycle.
  assign w_pop       = !w_empty && ((r_state == S_IDLE) || w_frame_end);
  assign w_head      = r_mem[r_rd_ptr];
  assign o_level     = r_count;

  // NOTE: storage has no reset; validity is tracked entirely by the pointers and count.
  always_ff @(posedge i_clk) begin
    if (w_push) r_mem[r_wr_ptr] <= {i_tlast, i_tdata};
  end

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
    end else begin
      if (w_push) r_wr_ptr <= r_wr_ptr + PTR_ONE;
      if (w_pop)  r_rd_ptr <= r_rd_ptr + PTR_ONE;
      r_count <= r_count + LW'(w_push) - LW'(w_pop);
    end
  end

  // NOTE: all state and outputs use non-blocking assignments so every branch sees
  // the pre-edge values of r_shift/r_bit, not ones updated earlier in the block.
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_state      <= S_IDLE;
      r_baud       <= '0;
      r_bit        <= '0;
      r_shift      <= '0;
      r_last       <= 1'b0;
      r_par        <= 1'b0;
      o_uart_tx    <= 1'b1;
      o_busy       <= 1'b0;
      o_frame_done <= 1'b0;
    end else begin
      o_frame_done <= 1'b0;
      if (w_pop) begin
        r_state      <= S_START;
        r_shift      <= w_head[7:0];
        r_last       <= w_head[8];
        r_par        <= (PARITY == 2) ? ^w_head[7:0] : ~^w_head[7:0];
        r_baud       <= DIV_M1;
        r_bit        <= '0;
        o_uart_tx    <= 1'b0;
        o_busy       <= 1'b1;
        o_frame_done <= w_frame_end && r_last;
      end else if (r_state == S_IDLE) begin
        o_uart_tx <= 1'b1;
        o_busy    <= 1'b0;
      end else if (r_baud != '0) begin
        r_baud <= r_baud - BAUD_ONE;
      end else begin
        r_baud <= DIV_M1;
        case (r_state)
          S_START: begin
            r_state   <= S_DATA;
            o_uart_tx <= r_shift[0];
          end
          S_DATA: begin
            if (r_bit == 3'd7) begin
              r_bit <= '0;
              if (PARITY != 0) begin
                r_state   <= S_PAR;
                o_uart_tx <= r_par;
              end else begin
                r_state   <= S_STOP;
                o_uart_tx <= 1'b1;
              end
            end else begin
              r_bit     <= r_bit + 3'd1;
              r_shift   <= {1'b0, r_shift[7:1]};
              o_uart_tx <= r_shift[1];
            end
          end
          S_PAR: begin
            r_state   <= S_STOP;
            r_bit     <= '0;
            o_uart_tx <= 1'b1;
          end
          S_STOP: begin
            if (r_bit == LAST_STOP) begin
              r_state      <= S_IDLE;
              r_bit        <= '0;
              o_uart_tx    <= 1'b1;
              o_busy       <= 1'b0;
              o_frame_done <= r_last;
            end else begin
              r_bit <= r_bit + 3'd1;
            end
          end
          default: begin
            r_state   <= S_IDLE;
            o_uart_tx <= 1'b1;
            o_busy    <= 1'b0;
          end
        endcase
      end
    end
  end

endmodule

// File: tb/tb_emitter_uart_fifo.sv
// Bench for emitter_uart_fifo: four instances (plain, even parity, odd parity, two stop
// bits) driven with fixed and random byte streams, checked against a frame-level model.
module tb_emitter_uart_fifo;

  localparam int N   = 4;
  localparam int DIV = 10;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic                 rst;
  logic [N-1:0][7:0]    tdata;
  logic [N-1:0]         tlast, tvalid;
  logic [N-1:0]         tready, tx, busy, fdone;
  logic [N-1:0][2:0]    level;

  int n_tests = 0;
  int n_fail  = 0;

  logic [7:0] byte_q[$];
  bit         last_q[$];
  bit         cap_tx[$], cap_busy[$], cap_fd[$], cap_rdy[$];
  int         cap_lvl[$];

  genvar g;
  generate
    for (g = 0; g < N; g++) begin : g_dut
      emitter_uart_fifo #(
        .CLK_FREQ (1000),
        .BAUD     (100),
        .DEPTH    (4),
        .STOP_BITS((g == 3) ? 2 : 1),
        .PARITY   ((g == 1) ? 2 : ((g == 2) ? 1 : 0))
      ) u_dut (
        .i_clk       (clk),
        .i_rst       (rst),
        .i_tdata     (tdata[g]),
        .i_tlast     (tlast[g]),
        .i_tvalid    (tvalid[g]),
        .o_tready    (tready[g]),
        .o_uart_tx   (tx[g]),
        .o_level     (level[g]),
        .o_busy      (busy[g]),
        .o_frame_done(fdone[g])
      );
    end
  endgenerate

  // ---------------- frame-level reference model ----------------
  function automatic int par_of(int u);
    return (u == 1) ? 2 : ((u == 2) ? 1 : 0);
  endfunction

  function automatic int stop_of(int u);
    return (u == 3) ? 2 : 1;
  endfunction

  function automatic int flen(int u);
    return (9 + ((par_of(u) != 0) ? 1 : 0) + stop_of(u)) * DIV;
  endfunction

  function automatic bit frame_bit(int u, logic [7:0] b, int c);
    int slot;
    slot = c / DIV;
    if (slot == 0) return 1'b0;
    if (slot <= 8) return b[slot-1];
    if (par_of(u) != 0 && slot == 9) return (par_of(u) == 2) ? ^b : ~^b;
    return 1'b1;
  endfunction

  // Captures start one cycle before the first write edge; the first start bit
  // therefore appears at sample index 2 and frames follow back to back.
  function automatic bit exp_val(int u, int kind, int i);
    int len, n;
    len = flen(u);
    n   = byte_q.size();
    if (kind == 0) begin
      if (i < 2 || i >= 2 + n*len) return 1'b1;
      return frame_bit(u, byte_q[(i-2)/len], (i-2) % len);
    end
    if (kind == 1) return (i >= 2 && i < 2 + n*len);
    for (int j = 0; j < n; j++)
      if (last_q[j] && i == 2 + (j+1)*len) return 1'b1;
    return 1'b0;
  endfunction

  function automatic int first_bad(int u, int kind);
    bit got;
    for (int i = 0; i < cap_tx.size(); i++) begin
      got = (kind == 0) ? cap_tx[i] : ((kind == 1) ? cap_busy[i] : cap_fd[i]);
      if (got !== exp_val(u, kind, i)) return i;
    end
    return -1;
  endfunction

  // ---------------- stimulus / capture ----------------
  task automatic run_stream(input int u, input int ncyc);
    cap_tx.delete(); cap_busy.delete(); cap_fd.delete(); cap_rdy.delete(); cap_lvl.delete();
    @(posedge clk); #1;
    fork
      begin
        for (int j = 0; j < byte_q.size(); j++) begin
          bit acc;
          int guard;
          acc   = 1'b0;
          guard = 0;
          tdata[u]  = byte_q[j];
          tlast[u]  = last_q[j];
          tvalid[u] = 1'b1;
          while (!acc && guard < 2000) begin
            @(negedge clk);
            acc = tready[u];
            @(posedge clk); #1;
            guard++;
          end
          n_tests++;
          if (!acc) begin
            n_fail++;
            $display("FAIL push_accept unit=%0d byte=%0d: accepted=%0b, required 1", u, j, acc);
          end
        end
        tvalid[u] = 1'b0;
        tdata[u]  = 8'hxx;
        tlast[u]  = 1'b0;
      end
      begin
        for (int i = 0; i < ncyc; i++) begin
          @(negedge clk);
          cap_tx.push_back(tx[u]);
          cap_busy.push_back(busy[u]);
          cap_fd.push_back(fdone[u]);
          cap_rdy.push_back(tready[u]);
          cap_lvl.push_back(int'(level[u]));
        end
      end
    join
  endtask

  // ---------------- tests ----------------
  task automatic test_reset;
    rst    = 1'b1;
    tvalid = '0;
    tlast  = '0;
    tdata  = '0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    n_tests++;
    if (tready !== 4'b0000) begin n_fail++; $display("FAIL reset_tready: got %b, expected 0000", tready); end
    n_tests++;
    if (tx !== 4'b1111) begin n_fail++; $display("FAIL reset_tx_in_reset: got %b, expected 1111", tx); end
    @(posedge clk); #1 rst = 1'b0;
    @(negedge clk);
    n_tests++;
    if (tx !== 4'b1111) begin n_fail++; $display("FAIL reset_tx: got %b, expected 1111", tx); end
    n_tests++;
    if (busy !== 4'b0000) begin n_fail++; $display("FAIL reset_busy: got %b, expected 0000", busy); end
    n_tests++;
    if (fdone !== 4'b0000) begin n_fail++; $display("FAIL reset_frame_done: got %b, expected 0000", fdone); end
    n_tests++;
    if (tready !== 4'b1111) begin n_fail++; $display("FAIL reset_tready_after: got %b, expected 1111", tready); end
    n_tests++;
    if (level !== '0) begin n_fail++; $display("FAIL reset_level: got %h, expected 0", level); end
  endtask

  task automatic test_single_frame;
    bit exp_bits[8] = '{1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1};
    int mm, cnt;
    byte_q = '{8'hA5};
    last_q = '{1'b0};
    run_stream(0, 2 + 100 + 10);
    mm = first_bad(0, 0);
    n_tests++;
    if (mm !== -1) begin n_fail++; $display("FAIL single_tx_stream: mismatch at cycle %0d, expected none", mm); end
    n_tests++;
    if (cap_tx[1] !== 1'b1 || cap_tx[2] !== 1'b0) begin
      n_fail++; $display("FAIL single_start_latency: got tx[1]=%0b tx[2]=%0b, expected 1 and 0", cap_tx[1], cap_tx[2]);
    end
    for (int s = 0; s < 8; s++) begin
      n_tests++;
      if (cap_tx[2 + DIV*(s+1) + 5] !== exp_bits[s]) begin
        n_fail++; $display("FAIL single_data_bit%0d: got %0b, expected %0b", s, cap_tx[2 + DIV*(s+1) + 5], exp_bits[s]);
      end
    end
    cnt = 0;
    foreach (cap_busy[i]) if (cap_busy[i]) cnt++;
    n_tests++;
    if (cnt !== 100) begin n_fail++; $display("FAIL single_busy_cycles: got %0d, expected 100", cnt); end
    n_tests++;
    if (cap_lvl[1] !== 1 || cap_lvl[2] !== 0) begin
      n_fail++; $display("FAIL single_level: got %0d,%0d, expected 1,0", cap_lvl[1], cap_lvl[2]);
    end
    mm = first_bad(0, 2);
    n_tests++;
    if (mm !== -1) begin n_fail++; $display("FAIL single_no_frame_done: pulse at cycle %0d, expected none", mm); end
  endtask

  task automatic test_fill_depth;
    int mm, max_lvl, bad_rdy, low_rdy;
    byte_q.delete(); last_q.delete();
    for (int j = 1; j <= 6; j++) begin
      byte_q.push_back(8'(j));
      last_q.push_back(1'b0);
    end
    run_stream(0, 2 + 600 + 20);
    mm = first_bad(0, 0);
    n_tests++;
    if (mm !== -1) begin n_fail++; $display("FAIL fill_tx_stream: mismatch at cycle %0d, expected none", mm); end
    mm = first_bad(0, 1);
    n_tests++;
    if (mm !== -1) begin n_fail++; $display("FAIL fill_busy: mismatch at cycle %0d, expected none", mm); end
    max_lvl = 0; bad_rdy = 0; low_rdy = 0;
    foreach (cap_lvl[i]) begin
      if (cap_lvl[i] > max_lvl) max_lvl = cap_lvl[i];
      if (cap_rdy[i] !== (cap_lvl[i] != 4)) bad_rdy++;
      if (!cap_rdy[i]) low_rdy++;
    end
    n_tests++;
    if (max_lvl !== 4) begin n_fail++; $display("FAIL fill_max_level: got %0d, expected 4", max_lvl); end
    n_tests++;
    if (bad_rdy !== 0) begin n_fail++; $display("FAIL fill_tready_vs_level: got %0d bad cycles, expected 0", bad_rdy); end
    n_tests++;
    if (low_rdy == 0) begin n_fail++; $display("FAIL fill_tready_drops: got %0d low cycles, expected >0", low_rdy); end
    n_tests++;
    if (cap_lvl[cap_lvl.size()-1] !== 0) begin
      n_fail++; $display("FAIL fill_final_level: got %0d, expected 0", cap_lvl[cap_lvl.size()-1]);
    end
  endtask

  task automatic test_parity;
    int mm, cnt;
    bit exp_p;
    for (int u = 1; u <= 2; u++) begin
      byte_q = '{8'h07};
      last_q = '{1'b0};
      run_stream(u, 2 + 110 + 10);
      exp_p = (u == 1) ? 1'b1 : 1'b0;
      n_tests++;
      if (cap_tx[2 + 9*DIV + 5] !== exp_p) begin
        n_fail++; $display("FAIL parity_bit unit=%0d: got %0b, expected %0b", u, cap_tx[2 + 9*DIV + 5], exp_p);
      end
      cnt = 0;
      foreach (cap_busy[i]) if (cap_busy[i]) cnt++;
      n_tests++;
      if (cnt !== 110) begin n_fail++; $display("FAIL parity_frame_len unit=%0d: got %0d, expected 110", u, cnt); end
      byte_q = '{8'($urandom_range(0, 255)), 8'($urandom_range(0, 255))};
      last_q = '{1'b0, 1'b0};
      run_stream(u, 2 + 220 + 10);
      mm = first_bad(u, 0);
      n_tests++;
      if (mm !== -1) begin n_fail++; $display("FAIL parity_random_stream unit=%0d: mismatch at cycle %0d, expected none", u, mm); end
    end
  endtask

  task automatic test_back_to_back;
    int mm, run;
    byte_q = '{8'h00, 8'hFF};
    last_q = '{1'b0, 1'b0};
    run_stream(3, 2 + 220 + 10);
    mm = first_bad(3, 0);
    n_tests++;
    if (mm !== -1) begin n_fail++; $display("FAIL b2b_tx_stream: mismatch at cycle %0d, expected none", mm); end
    run = 0;
    for (int i = 2 + 9*DIV; i < cap_tx.size() && cap_tx[i] === 1'b1; i++) run++;
    n_tests++;
    if (run !== 20) begin n_fail++; $display("FAIL b2b_stop_len: got %0d, expected 20", run); end
    n_tests++;
    if (cap_tx[2 + 110] !== 1'b0) begin n_fail++; $display("FAIL b2b_second_start: got %0b, expected 0", cap_tx[2 + 110]); end
    mm = first_bad(3, 1);
    n_tests++;
    if (mm !== -1) begin n_fail++; $display("FAIL b2b_busy: mismatch at cycle %0d, expected none", mm); end
  endtask

  task automatic test_frame_done;
    int cnt, pos;
    byte_q = '{8'h41, 8'h42};
    last_q = '{1'b0, 1'b1};
    run_stream(0, 2 + 200 + 10);
    cnt = 0; pos = -1;
    foreach (cap_fd[i]) if (cap_fd[i]) begin cnt++; pos = i; end
    n_tests++;
    if (cnt !== 1) begin n_fail++; $display("FAIL frame_done_count: got %0d, expected 1", cnt); end
    n_tests++;
    if (pos !== 202) begin n_fail++; $display("FAIL frame_done_cycle: got %0d, expected 202", pos); end
  endtask

  task automatic test_random;
    int mm;
    for (int u = 0; u < N; u++) begin
      byte_q.delete(); last_q.delete();
      for (int j = 0; j < 3; j++) begin
        byte_q.push_back(8'($urandom_range(0, 255)));
        last_q.push_back(1'($urandom_range(0, 1)));
      end
      run_stream(u, 2 + 3*flen(u) + 10);
      for (int k = 0; k < 3; k++) begin
        mm = first_bad(u, k);
        n_tests++;
        if (mm !== -1) begin n_fail++; $display("FAIL random unit=%0d kind=%0d: mismatch at cycle %0d, expected none", u, k, mm); end
      end
    end
  endtask

  task automatic test_reset_mid_frame;
    int mm, bad;
    byte_q = '{8'h11, 8'h22, 8'h33, 8'h44};
    last_q = '{1'b0, 1'b0, 1'b0, 1'b1};
    run_stream(0, 2 + 40);
    @(posedge clk); #1 rst = 1'b1;
    @(posedge clk); #1 rst = 1'b0;
    @(negedge clk);
    n_tests++;
    if (tx[0] !== 1'b1) begin n_fail++; $display("FAIL midreset_tx: got %0b, expected 1", tx[0]); end
    n_tests++;
    if (level[0] !== 3'd0) begin n_fail++; $display("FAIL midreset_level: got %0d, expected 0", level[0]); end
    n_tests++;
    if (busy[0] !== 1'b0) begin n_fail++; $display("FAIL midreset_busy: got %0b, expected 0", busy[0]); end
    bad = 0;
    repeat (300) begin
      @(negedge clk);
      if (tx[0] !== 1'b1 || busy[0] !== 1'b0 || level[0] !== 3'd0 || fdone[0] !== 1'b0) bad++;
    end
    n_tests++;
    if (bad !== 0) begin n_fail++; $display("FAIL midreset_quiet: got %0d active cycles, expected 0", bad); end
    byte_q = '{8'h5A};
    last_q = '{1'b1};
    run_stream(0, 2 + 100 + 10);
    mm = first_bad(0, 0);
    n_tests++;
    if (mm !== -1) begin n_fail++; $display("FAIL midreset_restart: mismatch at cycle %0d, expected none", mm); end
  endtask

  initial begin
    rst    = 1'b1;
    tvalid = '0;
    tlast  = '0;
    tdata  = '0;
    test_reset();
    test_single_frame();
    test_fill_depth();
    test_parity();
    test_back_to_back();
    test_frame_done();
    test_random();
    test_reset_mid_frame();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation time limit reached before summary");
    $fatal(1, "timeout");
  end

endmodule
